// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing data_mem between the MEM stage (port 0) and an aux master (port 1), with a port-1 burst lock.
// Grant is combinational; issue one cycle later; load data returns two cycles after grant. Optional DMEM_ARB_ALIGN_CHK_EN adds alignment errors.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [DATA_WIDTH-1:0] p0_addr,
  input  logic [CTRL_WIDTH-1:0] p0_ctrl,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [DATA_WIDTH-1:0] p1_addr,
  input  logic [CTRL_WIDTH-1:0] p1_ctrl,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic                  p1_lock,
  output logic                  p0_gnt,
  output logic                  p1_gnt,
  output logic                  p0_rvalid,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p0_err,
  output logic                  p1_err,
  output logic [DATA_WIDTH-1:0] mem_A,
  output logic                  mem_WE,
  output logic [CTRL_WIDTH-1:0] mem_ctrl,
  output logic [DATA_WIDTH-1:0] mem_WD,
  input  logic [DATA_WIDTH-1:0] mem_RD
);

  logic                  rr_last_q, lock_own_q;
  logic                  iss_valid_q, iss_port_q, iss_we_q;
  logic [DATA_WIDTH-1:0] iss_addr_q, iss_wd_q;
  logic [CTRL_WIDTH-1:0] iss_ctrl_q;
  logic                  rsp_valid_q, rsp_port_q, rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  logic                  any_gnt;
  logic [1:0]            iss_mode;
  logic                  mode_ok, iss_err;
  logic                  rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_d;

  // The lock only counts while p1 still asserts it, so ownership ends in the cycle p1_lock drops.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst_n) begin
      p0_gnt = 1'b0;
    end else if (lock_own_q && p1_lock && p1_req) begin
      p1_gnt = 1'b1;
    end else if (p0_req && p1_req) begin
      p0_gnt = rr_last_q;
      p1_gnt = ~rr_last_q;
    end else begin
      p0_gnt = p0_req;
      p1_gnt = p1_req & ~p0_req;
    end
  end

  assign any_gnt = p0_gnt | p1_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q   <= 1'b1;
      lock_own_q  <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_port_q  <= 1'b0;
      iss_we_q    <= 1'b0;
      iss_addr_q  <= '0;
      iss_ctrl_q  <= '0;
      iss_wd_q    <= '0;
    end else begin
      iss_valid_q <= any_gnt;
      lock_own_q  <= p1_gnt & p1_lock;
      if (any_gnt) begin
        rr_last_q  <= p1_gnt;
        iss_port_q <= p1_gnt;
        iss_we_q   <= p1_gnt ? p1_we    : p0_we;
        iss_addr_q <= p1_gnt ? p1_addr  : p0_addr;
        iss_ctrl_q <= p1_gnt ? p1_ctrl  : p0_ctrl;
        iss_wd_q   <= p1_gnt ? p1_wdata : p0_wdata;
      end
    end
  end

  assign iss_mode = iss_ctrl_q[1:0];
  assign mode_ok  = (iss_mode != 2'b11);

`ifdef DMEM_ARB_ALIGN_CHK_EN
  assign iss_err = ~mode_ok
                 | ((iss_mode == 2'b01) & iss_addr_q[0])
                 | ((iss_mode == 2'b10) & (|iss_addr_q[1:0]));
`else
  assign iss_err = 1'b0;
`endif

  assign mem_A    = iss_addr_q;
  assign mem_ctrl = iss_ctrl_q;
  assign mem_WD   = iss_wd_q;
  assign mem_WE   = iss_valid_q & iss_we_q & mode_ok & ~iss_err;

  // Stores only answer when they are rejected as errors.
  assign rsp_valid_d = iss_valid_q & (~iss_we_q | iss_err);
  assign rsp_data_d  = (mode_ok & ~iss_err) ? mem_RD : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_port_q  <= iss_port_q;
      rsp_err_q   <= iss_err;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign p0_rvalid = rsp_valid_q & ~rsp_port_q;
  assign p1_rvalid = rsp_valid_q & rsp_port_q;
  assign p0_rdata  = p0_rvalid ? rsp_data_q : '0;
  assign p1_rdata  = p1_rvalid ? rsp_data_q : '0;
  assign p0_err    = p0_rvalid & rsp_err_q;
  assign p1_err    = p1_rvalid & rsp_err_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester controller that shares the single-port, byte-addressed data memory between the pipeline MEM stage (port 0) and an auxiliary master (port 1: program loader/debug).
- Arbitrates round-robin, with an optional lock for port-1 bursts.
- Registers the winning request into an issue stage that drives the memory. Read data returns registered, with a fixed latency.
- Sits between the pipelined core / aux master and data_mem. The core stalls MEM on !p0_gnt.

Parameters:
- DATA_WIDTH, 32, width of address and data buses.
- CTRL_WIDTH, 3, addressing-control width: {zero_extend, mode[1:0]}; mode 00 = byte, 01 = half, 10 = word, 11 = invalid.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- p0_req / p1_req  in  1  request valid.
- p0_we / p1_we  in  1  1 = store, 0 = load.
- p0_addr / p1_addr  in  DATA_WIDTH  byte address.
- p0_ctrl / p1_ctrl  in  CTRL_WIDTH  addressing control.
- p0_wdata / p1_wdata  in  DATA_WIDTH  store data.
- p1_lock  in  1  port 1 holds ownership while asserted.
- p0_gnt / p1_gnt  out  1  request accepted this cycle.
- p0_rvalid / p1_rvalid  out  1  one-cycle read-response pulse.
- p0_rdata / p1_rdata  out  DATA_WIDTH  load result, valid with rvalid.
- p0_err / p1_err  out  1  error pulse, coincident with rvalid (see Optional Feature).
- mem_A  out  DATA_WIDTH  to data_mem A.
- mem_WE  out  1  to data_mem WE.
- mem_ctrl  out  CTRL_WIDTH  to data_mem AddressingControl.
- mem_WD  out  DATA_WIDTH  to data_mem WD.
- mem_RD  in  DATA_WIDTH  from data_mem RD (combinational read).

Behaviour:
- Reset (async, rst_n=0): all outputs go to 0 immediately.
  - iss_valid=0, rsp_valid=0, rr_last=1 (so port 0 wins first), lock_own=0.
  - mem_WE must drop asynchronously, so no write can occur in a reset cycle.
  - In-flight request and pending response are discarded; no rvalid after reset.
- Pipeline, one request per cycle:
  - Cycle N: arbitration; gnt is combinational from req and state; the grantee is captured into the issue register at the edge.
  - Cycle N+1: issue register drives mem_A, mem_ctrl, mem_WD, and mem_WE = iss_valid & iss_we & valid_mode. The store commits at the end of N+1.
  - Cycle N+2: loads only; rvalid pulses for the owning port, rdata = mem_RD sampled at end of N+1. Stores produce no rvalid.
- Arbitration:
  - Only one requester: it is granted.
  - Both requesting: grant the port != rr_last. rr_last updates to the granted port on every grant.
  - Lock: if lock_own=1 and p1_req=1, p1 is granted regardless of rr.
    - lock_own sets on a p1 grant with p1_lock=1.
    - lock_own clears when p1_lock=0 or p1_req=0.
  - No requests: no grant, iss_valid=0 next cycle, memory outputs hold their last address/data with mem_WE=0.
- Ordering hazard: a load issued the cycle after a store to the same address returns the new data. This holds by construction, because the store commits before the load's issue cycle.
- mode 11: request is granted; mem_WE forced 0. A load returns rdata=0 with rvalid; err=0 unless the feature is enabled.
- Non-granted requester must hold its request stable; the arbiter does not buffer it.
- Read data is passed unmodified; sign/zero extension is done by data_mem.

Optional Feature:
- DMEM_ARB_ALIGN_CHK_EN defined:
  - Accesses are misaligned when a half has addr[0]=1 or a word has addr[1:0]≠0; mode 11 is also an error.
  - Erroneous accesses are granted but not performed: mem_WE=0.
  - At N+2 the arbiter pulses rvalid and err for the owner with rdata=0, for both loads and stores.
- Undefined: no alignment check. Misaligned accesses pass to memory unchanged and err is tied 0.

Test Plan:
- Reset release, then p0 store word 0xDEADBEEF to 0x100 and p0 load word 0x100 the next cycle -> mem_WE high one cycle; p0_rvalid at load-grant+2 with rdata=0xDEADBEEF.
- p0 and p1 both request loads for 4 cycles -> grants alternate p0,p1,p0,p1; each rvalid arrives 2 cycles after its grant, tagged to the correct port.
- p1 asserts lock with continuous req for 3 cycles while p0 requests -> p1 granted 3 consecutive cycles; p0 granted on the cycle lock drops.
- rst_n pulsed low in the cycle after a store grant -> mem_WE low during reset; memory at the target address unchanged; no rvalid after release.
- Load with ctrl=3'b011 -> granted; mem_WE=0; rvalid with rdata=0.
- Feature on: p1 store word to 0x102 -> no memory write; p1_rvalid=1, p1_err=1 at grant+2. Feature off: same store writes bytes 0x102..0x105.
